abs_restore: RTL and testbench
==============================

ABS_RESTORE -- requirements
Module: abs_restore

Interface
REQ-001 The block SHALL have parameter SAT_MAG, default 7'h7F, the magnitude code counted as saturated.
REQ-002 The block SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-003 The block SHALL have port Reset  input  1  reset, synchronous and active-high.
REQ-004 The block SHALL have port in_valid  input  1  upstream sample present.
REQ-005 The block SHALL have port in_ready  output  1  block accepts a sample this cycle.
REQ-006 The block SHALL have port sign  input  1  sample sign, 1 = negative.
REQ-007 The block SHALL have port magnitude  input  7  unsigned sample magnitude.
REQ-008 The block SHALL have port clr_cnt  input  1  clear the saturation counter.
REQ-009 The block SHALL have port out_valid  output  1  out_value holds a valid result.
REQ-010 The block SHALL have port out_ready  input  1  downstream accepts the result.
REQ-011 The block SHALL have port out_value  output  8  two's-complement result.
REQ-012 The block SHALL have port sat_cnt  output  8  count of accepted samples with magnitude == SAT_MAG.
REQ-013 The block SHALL have port sat_ov  output  1  one-cycle pulse when sat_cnt wraps.

Function
REQ-014 An input transfer SHALL occur when in_valid && in_ready on a rising clk edge; an output transfer when out_valid && out_ready.
REQ-015 The pipeline SHALL have two stages: S1 registers sign/magnitude; S2 computes and holds out_value.
REQ-016 out_value SHALL be {1'b0, magnitude} for sign=0, and the 8-bit two's complement negation of {1'b0, magnitude} for sign=1.
REQ-017 sign=1 with magnitude=0 SHALL yield out_value 8'h00.
REQ-018 The range SHALL be -127..+127; 8'h80 SHALL never be produced.
REQ-019 With out_ready held high, latency SHALL be 2 cycles from input transfer to out_valid, at a throughput of one sample per cycle.
REQ-020 Each stage SHALL advance when it is empty or when its successor advances or is empty.
REQ-021 in_ready SHALL equal !(S1 valid && S2 valid && !out_ready).
REQ-022 While out_valid && !out_ready, out_value SHALL stay stable, and no sample SHALL be lost or duplicated.
REQ-023 sat_cnt SHALL increment by 1 on each input transfer with magnitude == SAT_MAG, regardless of sign.
REQ-024 sat_cnt SHALL wrap 8'hFF to 8'h00, and sat_ov SHALL be high for exactly the cycle after the wrap edge.
REQ-025 clr_cnt SHALL set sat_cnt to 0 on the next edge, and clr_cnt SHALL win over a simultaneous increment.
REQ-026 clr_cnt SHALL NOT affect the data pipeline.

Reset
REQ-027 Reset SHALL be sampled only on rising clk edges and SHALL override all other inputs.
REQ-028 On reset, S1/S2 valid SHALL clear, out_valid=0, out_value=8'h00, sat_cnt=8'h00 and sat_ov=0.
REQ-029 in_ready SHALL be 1 in the cycle after reset deasserts.
REQ-030 Reset mid-stream SHALL discard in-flight samples without emitting them.

Structure
REQ-031 The shared package SHALL hold data width 8, magnitude width 7, the SAT_MAG default and the counter width 8.
REQ-032 The saturation counter SHALL be one sub-module, sat_counter (clk, Reset, inc, clr, count, ov), reusing the team's 8-bit counter behaviour with synchronous reset.
REQ-033 The negation SHALL be combinational logic feeding the S2 register.

Verification
REQ-034 Stream sign/mag (0,5), (1,5), (1,0), (0,127), (1,127) with out_ready=1 -> out_value 05, FB, 00, 7F, 81, each 2 cycles after its input transfer.
REQ-035 out_ready=0 for 4 cycles while in_valid=1 -> 2 samples accepted, then in_ready=0; on release, all outputs appear in order with none lost.
REQ-036 Send 256 samples with magnitude 127 -> sat_cnt reaches FF then 00, with a sat_ov pulse of exactly one cycle.
REQ-037 clr_cnt asserted in the same cycle as a magnitude-127 transfer with sat_cnt=3 -> sat_cnt=0 next cycle.
REQ-038 Reset asserted with 2 samples in flight -> out_valid=0 next cycle; those samples are never output.
REQ-039 Sweep all 256 sign/magnitude codes -> out_value matches the signed reference value and is never 8'h80.

Source files
------------

// File: rtl/abs_restore_pkg.sv
// Shared widths, defaults and the sign/magnitude to two's-complement helper
// for the abs_restore block.
package abs_restore_pkg;

   localparam int unsigned DataWidth = 8;
   localparam int unsigned MagWidth  = 7;
   localparam int unsigned CntWidth  = 8;

   localparam logic [MagWidth-1:0] SatMagDefault = 7'h7F;

   // Magnitude is at most 127, so the result spans -127..+127 and never hits 8'h80.
   function automatic logic [DataWidth-1:0] to_twos(input logic                neg,
                                                    input logic [MagWidth-1:0] mag);
      logic [DataWidth-1:0] ext;
      logic [DataWidth-1:0] zero;
      ext  = {1'b0, mag};
      zero = '0;
      return neg ? (zero - ext) : ext;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Wrapping 8-bit event counter with synchronous reset, priority clear and a
// one-cycle overflow pulse following the wrap edge.
module sat_counter
   import abs_restore_pkg::*;
(
   input  logic                clk,
   input  logic                Reset,
   input  logic                inc,
   input  logic                clr,
   output logic [CntWidth-1:0] count,
   output logic                ov
);

   always_ff @(posedge clk) begin
      if (Reset) begin
         count <= '0;
         ov    <= 1'b0;
      end else begin
         ov <= inc && !clr && (count == '1);
         if (clr) begin
            count <= '0;
         end else if (inc) begin
            count <= count + CntWidth'(1);
         end
      end
   end

endmodule

// File: rtl/abs_restore.sv
// Two-stage valid/ready pipeline turning sign/magnitude samples into
// two's-complement values, with a count of saturated-magnitude inputs.
module abs_restore
   import abs_restore_pkg::*;
#(
   parameter logic [MagWidth-1:0] SAT_MAG = SatMagDefault
) (
   input  logic                 clk,
   input  logic                 Reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 sign,
   input  logic [MagWidth-1:0]  magnitude,
   input  logic                 clr_cnt,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [DataWidth-1:0] out_value,
   output logic [CntWidth-1:0]  sat_cnt,
   output logic                 sat_ov
);

   logic                 s1_valid;
   logic                 s1_sign;
   logic [MagWidth-1:0]  s1_mag;
   logic [DataWidth-1:0] s2_value_d;
   logic                 s1_adv;
   logic                 s2_adv;
   logic                 in_xfer;
   logic                 sat_inc;

   // S2 (out_valid/out_value) moves when empty or drained; S1 moves when empty or S2 moves.
   assign s2_adv     = !out_valid || out_ready;
   assign s1_adv     = !s1_valid || s2_adv;
   assign in_ready   = s1_adv;
   assign in_xfer    = in_valid && in_ready;
   assign s2_value_d = to_twos(s1_sign, s1_mag);
   assign sat_inc    = in_xfer && (magnitude == SAT_MAG);

   always_ff @(posedge clk) begin
      if (Reset) begin
         s1_valid  <= 1'b0;
         s1_sign   <= 1'b0;
         s1_mag    <= '0;
         out_valid <= 1'b0;
         out_value <= '0;
      end else begin
         if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
               s1_sign <= sign;
               s1_mag  <= magnitude;
            end
         end
         if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
               out_value <= s2_value_d;
            end
         end
      end
   end

   sat_counter u_sat_counter (
      .clk   (clk),
      .Reset (Reset),
      .inc   (sat_inc),
      .clr   (clr_cnt),
      .count (sat_cnt),
      .ov    (sat_ov)
   );

endmodule

// File: tb/tb_abs_restore.sv
// Randomized self-checking bench for abs_restore against a queue-based
// behavioural model, plus directed literal scenarios.
module tb_abs_restore;

   logic       clk = 1'b0;
   logic       Reset = 1'b1;
   logic       in_valid = 1'b0;
   logic       sign = 1'b0;
   logic [6:0] magnitude = '0;
   logic       clr_cnt = 1'b0;
   logic       out_ready = 1'b1;
   logic       in_ready;
   logic       out_valid;
   logic [7:0] out_value;
   logic [7:0] sat_cnt;
   logic       sat_ov;

   abs_restore dut (
      .clk       (clk),
      .Reset     (Reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .sign      (sign),
      .magnitude (magnitude),
      .clr_cnt   (clr_cnt),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_value (out_value),
      .sat_cnt   (sat_cnt),
      .sat_ov    (sat_ov)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] v;
      int         stamp;
   } item_t;

   item_t      q[$];
   logic [7:0] got[$];
   int         ecnt = 0;
   int         mcnt = 0;
   bit         mov = 1'b0;
   bit         armed = 1'b0;
   bit         capture = 1'b0;
   bit         rand_ready = 1'b0;
   int         ov_pulses = 0;
   int         checks = 0;
   int         errors = 0;

   function automatic logic [7:0] ref_val(input bit s, input logic [6:0] m);
      int v;
      v = s ? -int'(m) : int'(m);
      return v[7:0];
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) ecnt++;

   always @(posedge clk) begin
      if (rand_ready) begin
         #1;
         out_ready = ($urandom_range(0, 3) != 0);
      end
   end

   // Compare then advance the model for the coming edge.
   always @(negedge clk) begin
      bit ev;
      bit er;
      bit inc;
      ev = (q.size() > 0) && (q[0].stamp < ecnt);
      er = !((q.size() == 2) && !out_ready);
      if (armed) begin
         check("in_ready", 32'(in_ready), 32'(er));
         check("out_valid", 32'(out_valid), 32'(ev));
         if (ev) begin
            check("out_value", 32'(out_value), 32'(q[0].v));
            check("not_80", 32'(out_value == 8'h80), 32'(0));
         end
         check("sat_cnt", 32'(sat_cnt), 32'(mcnt));
         check("sat_ov", 32'(sat_ov), 32'(mov));
         if (sat_ov) ov_pulses++;
         if (capture && out_valid && out_ready) got.push_back(out_value);
      end
      if (Reset) begin
         q.delete();
         mcnt  = 0;
         mov   = 1'b0;
         armed = 1'b1;
      end else begin
         if (ev && out_ready) void'(q.pop_front());
         inc = in_valid && er && (magnitude == 7'h7F);
         if (in_valid && er) q.push_back('{v: ref_val(sign, magnitude), stamp: ecnt + 1});
         mov  = !clr_cnt && inc && (mcnt == 255);
         mcnt = clr_cnt ? 0 : (inc ? (mcnt + 1) % 256 : mcnt);
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic send(input bit s, input logic [6:0] m);
      int guard;
      bit ok;
      guard = 0;
      in_valid  = 1'b1;
      sign      = s;
      magnitude = m;
      do begin
         ok = in_ready;
         step();
         guard++;
      end while (!ok && guard < 200);
      if (!ok) check("send_timeout", 32'(0), 32'(1));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bit         ss[3];
      logic [6:0] mm[3];
      int         acc;
      int         idx;
      bit         ok;

      // Reset state
      step();
      step();
      Reset = 1'b0;
      check("rst_out_valid", 32'(out_valid), 32'(0));
      check("rst_out_value", 32'(out_value), 32'(8'h00));
      check("rst_sat_cnt", 32'(sat_cnt), 32'(8'h00));
      check("rst_sat_ov", 32'(sat_ov), 32'(0));
      check("rst_in_ready", 32'(in_ready), 32'(1));

      // Directed stream with literal results
      got.delete();
      capture = 1'b1;
      send(1'b0, 7'd5);
      send(1'b1, 7'd5);
      send(1'b1, 7'd0);
      send(1'b0, 7'd127);
      send(1'b1, 7'd127);
      in_valid = 1'b0;
      repeat (4) step();
      capture = 1'b0;
      check("stream_count", 32'(got.size()), 32'(5));
      if (got.size() == 5) begin
         check("stream_0", 32'(got[0]), 32'(8'h05));
         check("stream_1", 32'(got[1]), 32'(8'hFB));
         check("stream_2", 32'(got[2]), 32'(8'h00));
         check("stream_3", 32'(got[3]), 32'(8'h7F));
         check("stream_4", 32'(got[4]), 32'(8'h81));
      end

      // Backpressure: only two samples fit while stalled
      ss = '{1'b1, 1'b0, 1'b0};
      mm = '{7'd3, 7'd9, 7'd20};
      got.delete();
      capture   = 1'b1;
      out_ready = 1'b0;
      idx       = 0;
      acc       = 0;
      in_valid  = 1'b1;
      sign      = ss[0];
      magnitude = mm[0];
      for (int c = 0; c < 4; c++) begin
         ok = in_ready;
         step();
         if (ok) begin
            acc++;
            if (idx < 2) idx++;
            sign      = ss[idx];
            magnitude = mm[idx];
         end
      end
      check("stall_accepted", 32'(acc), 32'(2));
      check("stall_in_ready", 32'(in_ready), 32'(0));
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (4) step();
      capture = 1'b0;
      check("stall_drained", 32'(got.size()), 32'(2));
      if (got.size() == 2) begin
         check("stall_0", 32'(got[0]), 32'(8'hFD));
         check("stall_1", 32'(got[1]), 32'(8'h09));
      end

      // Clear wins over a simultaneous increment
      clr_cnt = 1'b1;
      step();
      clr_cnt = 1'b0;
      repeat (3) send(1'b0, 7'd127);
      in_valid = 1'b0;
      check("cnt_three", 32'(sat_cnt), 32'(3));
      clr_cnt = 1'b1;
      send(1'b1, 7'd127);
      in_valid = 1'b0;
      clr_cnt  = 1'b0;
      check("clr_wins", 32'(sat_cnt), 32'(0));

      // 256 saturated samples wrap the counter once
      ov_pulses = 0;
      for (int i = 0; i < 255; i++) send(1'($urandom_range(0, 1)), 7'd127);
      check("cnt_ff", 32'(sat_cnt), 32'(8'hFF));
      send(1'b0, 7'd127);
      in_valid = 1'b0;
      check("cnt_wrap", 32'(sat_cnt), 32'(8'h00));
      check("ov_high", 32'(sat_ov), 32'(1));
      step();
      check("ov_low", 32'(sat_ov), 32'(0));
      repeat (3) step();
      check("ov_pulses", 32'(ov_pulses), 32'(1));

      // Reset discards in-flight samples
      got.delete();
      capture   = 1'b1;
      out_ready = 1'b0;
      send(1'b0, 7'd11);
      send(1'b1, 7'd22);
      in_valid = 1'b0;
      Reset    = 1'b1;
      step();
      Reset = 1'b0;
      check("rst_flush_valid", 32'(out_valid), 32'(0));
      out_ready = 1'b1;
      repeat (4) step();
      capture = 1'b0;
      check("rst_flush_none", 32'(got.size()), 32'(0));

      // Full code sweep under random backpressure
      rand_ready = 1'b1;
      for (int i = 0; i < 256; i++) begin
         logic [7:0] code;
         code = 8'(i);
         send(code[7], code[6:0]);
      end

      // Random traffic with gaps and clears
      for (int i = 0; i < 300; i++) begin
         clr_cnt = ($urandom_range(0, 15) == 0);
         if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            step();
         end else if ($urandom_range(0, 2) == 0) begin
            send(1'($urandom_range(0, 1)), 7'd127);
         end else begin
            send(1'($urandom_range(0, 1)), 7'($urandom_range(0, 127)));
         end
      end
      clr_cnt    = 1'b0;
      in_valid   = 1'b0;
      rand_ready = 1'b0;
      #1;
      out_ready = 1'b1;
      repeat (5) step();
      check("drained", 32'(q.size()), 32'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
